// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its queue.
// Holds the FSM encoding, queue entry width and the branch-target helper.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_FETCH   = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // Queue entries are {pc, instr}.
    localparam int QUEUE_W = 64;

    function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                  input logic [15:0] imm);
        return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_queue.sv
// In-order instruction queue of {pc, instr} entries between fetch and decode.
// flush wins over push and pop in the same cycle; pop on empty is ignored.
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [QUEUE_W-1:0]     push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [QUEUE_W-1:0]     head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [QUEUE_W-1:0] mem_q [DEPTH];
    logic [QUEUE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];
    assign do_push   = push & ~full & ~flush;
    assign do_pop    = pop & ~empty & ~flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction-memory
// request, queues returned words and redirects on a taken branch from decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        jump
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_state_e       state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic               outstanding_q, outstanding_d;

    logic               q_push, q_pop, q_flush, q_full, q_empty;
    logic [CNT_W-1:0]   q_count;
    logic [QUEUE_W-1:0] q_head;
    logic               xfer, take;
    logic [31:0]        target;

    // Handshakes: memory transfers on imem_req & imem_ack, with req/addr held
    // stable from rise to ack; decode pops on instr_valid & instr_ready.
    assign imem_req  = (state_q == FETCH_DISCARD) ||
                       ((state_q == FETCH_FETCH) && (outstanding_q || (q_count < FULL_CNT)));
    assign imem_addr = fetch_pc_q;
    assign xfer      = imem_req & imem_ack;

    assign instr_valid = ~q_empty;
    assign instr       = q_empty ? INSTR_NOP : q_head[31:0];
    assign pc          = q_empty ? 32'h0 : q_head[63:32];
    assign pc_plus4    = pc + PC_STEP;
    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];

    assign q_pop   = instr_valid & instr_ready;
    assign take    = q_pop & jump;
    assign q_flush = take;
    assign target  = branch_target(pc_plus4, instr[15:0]);

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (q_push),
        .push_data({fetch_pc_q, imem_rdata}),
        .pop      (q_pop),
        .flush    (q_flush),
        .head_data(q_head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count)
    );

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        redirect_pc_d = redirect_pc_q;
        q_push        = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_FETCH;
            end
            FETCH_FETCH: begin
                if (take) begin
                    // A request already raised must finish before we can move on.
                    if (imem_req && !imem_ack) begin
                        redirect_pc_d = target;
                        state_d       = FETCH_DISCARD;
                    end else begin
                        fetch_pc_d = target;
                    end
                end else if (xfer) begin
                    q_push     = ~q_full;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                end
            end
            FETCH_DISCARD: begin
                if (imem_ack) begin
                    fetch_pc_d = redirect_pc_q;
                    state_d    = FETCH_FETCH;
                end
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
        outstanding_d = imem_req & ~imem_ack;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH_IDLE;
            fetch_pc_q    <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            outstanding_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            redirect_pc_q <= redirect_pc_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory model with programmable ack latency, an
// expected-entry queue for decode-side output, a branch vector table and corner sequences.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 2;

    logic        clk, rst_n;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instr, pc, pc_plus4;
    logic        instr_valid, instr_ready, jump;
    logic [5:0]  opcode, funct;

    fetch_stage #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .opcode     (opcode),
        .funct      (funct),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .jump       (jump)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];
    int          ack_lat, wait_cnt, xfer_cnt;
    bit          rand_lat, discarding, prev_pend;
    logic [31:0] prev_addr, exp_fetch, redir;
    logic [31:0] ovr_addr, ovr_word;

    typedef struct {
        logic [15:0] imm;
        int          mode;   // 0: no request in flight, 1: ack same cycle, 2: request pending
        logic [31:0] target;
    } br_vec_t;

    br_vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == ovr_addr) return ovr_word;
        return a * 32'h0001_0001 + 32'h1357_9BDF;
    endfunction

    task automatic mem_drive();
        if (imem_req && wait_cnt >= ack_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end
    endtask

    // Scoreboard step, run once per cycle just before the active edge.
    task automatic sb_observe();
        logic [63:0] e;
        logic [31:0] e_pc4, tgt;
        logic        pop, take;
        e    = '0;
        tgt  = '0;
        pop  = instr_valid && instr_ready;
        take = pop && jump && (exp_q.size() != 0);
        check("valid_vs_model", instr_valid, exp_q.size() != 0);
        if (exp_q.size() == 0) begin
            check("empty_instr", instr, 32'h0);
            check("empty_pc", pc, 32'h0);
        end
        if (prev_pend) begin
            check("req_held", imem_req, 1'b1);
            check("addr_held", imem_addr, prev_addr);
        end else if (imem_req) begin
            check("req_addr", imem_addr, exp_fetch);
        end
        if (pop && exp_q.size() != 0) begin
            e     = exp_q.pop_front();
            e_pc4 = e[63:32] + 32'd4;
            tgt   = e_pc4 + {{14{e[15]}}, e[15:0], 2'b00};
            check("head_pc", pc, e[63:32]);
            check("head_instr", instr, e[31:0]);
            check("pc_plus4", pc_plus4, e_pc4);
            check("opcode", opcode, e[31:26]);
            check("funct", funct, e[5:0]);
        end
        if (imem_req && imem_ack) begin
            xfer_cnt++;
            wait_cnt = 0;
            if (rand_lat) ack_lat = $urandom_range(0, 3);
            if (discarding) begin
                discarding = 0;
                exp_fetch  = redir;
            end else if (!take) begin
                exp_q.push_back({imem_addr, imem_rdata});
                exp_fetch = imem_addr + 32'd4;
            end
        end else if (imem_req) begin
            wait_cnt++;
        end
        if (take) begin
            exp_q.delete();
            if (imem_req && !imem_ack) begin
                discarding = 1;
                redir      = tgt;
            end else begin
                exp_fetch = tgt;
            end
        end
        prev_pend = imem_req && !imem_ack;
        prev_addr = imem_addr;
    endtask

    task automatic tick();
        #2;
        sb_observe();
        @(posedge clk);
        #1;
        mem_drive();
    endtask

    task automatic reset_assert();
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        jump        = 1'b0;
        exp_q.delete();
        discarding  = 0;
        prev_pend   = 0;
        wait_cnt    = 0;
        xfer_cnt    = 0;
        exp_fetch   = RESET_PC;
        #1;
        mem_drive();
    endtask

    task automatic reset_release();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_pc_plus4", pc_plus4, 32'h4);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mem_drive();
    endtask

    initial begin
        logic [31:0] tgt_next;
        int          n;
        vecs[0] = '{imm: 16'h0003, mode: 0, target: 32'h0000_0110};
        vecs[1] = '{imm: 16'hFFFF, mode: 0, target: 32'h0000_0100};
        vecs[2] = '{imm: 16'hFFBE, mode: 0, target: 32'hFFFF_FFFC};
        vecs[3] = '{imm: 16'h8000, mode: 0, target: 32'hFFFE_0104};
        vecs[4] = '{imm: 16'h0003, mode: 1, target: 32'h0000_0110};
        vecs[5] = '{imm: 16'h0003, mode: 2, target: 32'h0000_0110};
        vecs[6] = '{imm: 16'hFFFF, mode: 2, target: 32'h0000_0100};

        ack_lat    = 0;
        rand_lat   = 0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        ovr_addr   = RESET_PC;
        ovr_word   = {6'h04, 5'd1, 5'd2, 16'h0003};

        // Streaming with a zero-wait memory and decode always ready.
        reset_assert();
        instr_ready = 1'b1;
        reset_release();
        check("t1_addr0", imem_addr, 32'h100);
        check("t1_valid0", instr_valid, 1'b0);
        tick();
        check("t1_addr1", imem_addr, 32'h104);
        check("t1_valid1", instr_valid, 1'b1);
        check("t1_pc1", pc, 32'h100);
        tick();
        check("t1_addr2", imem_addr, 32'h108);
        check("t1_pc2", pc, 32'h104);

        // Decode stalled: the queue fills after exactly DEPTH transfers, then drains.
        reset_assert();
        reset_release();
        tick();
        tick();
        repeat (3) tick();
        check("t2_xfers", xfer_cnt, 2);
        check("t2_req_off", imem_req, 1'b0);
        check("t2_pc_held", pc, 32'h100);
        check("t2_instr_held", instr, mem_word(32'h100));
        instr_ready = 1'b1;
        tick();
        check("t2_pc_next", pc, 32'h104);
        check("t2_resume_req", imem_req, 1'b1);
        check("t2_resume_addr", imem_addr, 32'h108);
        tick();
        check("t2_pc_resumed", pc, 32'h108);

        // Branch redirect vectors: the head is the BEQ word at RESET_PC.
        for (int i = 0; i < 7; i++) begin
            ovr_word = {6'h04, 5'd1, 5'd2, vecs[i].imm};
            ack_lat  = 0;
            reset_assert();
            reset_release();
            if (vecs[i].mode == 0) begin
                tick();
                tick();
                check("br_full_noreq", imem_req, 1'b0);
            end else if (vecs[i].mode == 1) begin
                tick();
                check("br_ack_now", imem_ack, 1'b1);
            end else begin
                ack_lat = 3;
                tick();
                check("br_pending", {imem_req, imem_ack}, 2'b10);
            end
            check("br_head_pc", pc, RESET_PC);
            check("br_head_opcode", opcode, 6'h04);
            instr_ready = 1'b1;
            jump        = 1'b1;
            tick();
            jump = 1'b0;
            check("br_flushed", instr_valid, 1'b0);
            if (vecs[i].mode == 2) begin
                n = 0;
                while (!(imem_req && imem_ack) && n < 8) begin
                    check("br_disc_addr", imem_addr, RESET_PC + 32'd4);
                    check("br_disc_valid", instr_valid, 1'b0);
                    tick();
                    n++;
                end
                check("br_disc_ack_seen", n < 8, 1'b1);
                check("br_disc_ack_addr", imem_addr, RESET_PC + 32'd4);
                tick();
                check("br_disc_dropped", instr_valid, 1'b0);
                ack_lat = 0;
                mem_drive();
            end
            check("br_target_req", imem_req, 1'b1);
            check("br_target_addr", imem_addr, vecs[i].target);
            tick();
            tgt_next = vecs[i].target + 32'd4;
            check("br_next_addr", imem_addr, tgt_next);
            check("br_target_pc", pc, vecs[i].target);
        end

        // Asynchronous reset while a request is pending.
        ovr_word = {6'h04, 5'd1, 5'd2, 16'h0003};
        ack_lat  = 0;
        reset_assert();
        reset_release();
        ack_lat = 3;
        tick();
        check("t6_pre_req", {imem_req, imem_ack}, 2'b10);
        check("t6_pre_valid", instr_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_req_async", imem_req, 1'b0);
        check("t6_valid_async", instr_valid, 1'b0);
        reset_assert();
        ack_lat = 0;
        reset_release();
        check("t6_first_req", imem_req, 1'b1);
        check("t6_first_addr", imem_addr, RESET_PC);

        // Random soak: random latency, stalls and jumps against the model.
        rand_lat = 1;
        ack_lat  = $urandom_range(0, 3);
        reset_assert();
        reset_release();
        for (int c = 0; c < 400; c++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            jump        = ($urandom_range(0, 4) == 0);
            tick();
        end
        jump        = 1'b0;
        instr_ready = 1'b1;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
